// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// ALU control codes and the sequencer state encoding.
package ex_pkg;

  // ALU control codes seen by the EX stage
  localparam logic [4:0] ALU_ADD = 5'b00110;
  localparam logic [4:0] ALU_SUB = 5'b00111;
  localparam logic [4:0] ALU_MUL = 5'b01000;
  localparam logic [4:0] ALU_DIV = 5'b01001;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;
  localparam logic [4:0] ALU_SHL = 5'b01100;
  localparam logic [4:0] ALU_SHR = 5'b01101;
  localparam logic [4:0] ALU_CMP = 5'b01110;
  localparam logic [4:0] ALU_NOT = 5'b01111;
  localparam logic [4:0] ALU_NOP = 5'b11111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> multi-cycle MUL/DIV sequencer interface.
// master: pipeline side (drives instruction, receives stall/result).
// slave:  sequencer side.
interface ex_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             flush;
  logic [4:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output valid_in, flush, alu_ctrl, op_a, op_b,
    input  stall, busy, result_valid, result, remainder, div_by_zero
  );

  modport slave (
    input  valid_in, flush, alu_ctrl, op_a, op_b,
    output stall, busy, result_valid, result, remainder, div_by_zero
  );
endinterface

// File: rtl/ex_muldiv_datapath.sv
// Operand, accumulator and quotient/multiplier shift registers for the
// iterative shift-add multiplier and unsigned restoring divider, plus the
// registered result fields. One load / iterate / finish step per cycle.
module ex_muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,     // capture operands, clear accumulator
  input  logic             div_sel,  // 1: divide, 0: multiply
  input  logic             iterate,  // perform one iteration
  input  logic             finish,   // last iteration: publish result fields
  input  logic             early,    // trivial operation resolved at start
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // opnd_q: multiplicand (MUL) or divisor (DIV)
  // acc_q : high partial product (MUL) or partial remainder (DIV)
  // q_q   : multiplier shifting out / product low half (MUL),
  //         dividend shifting out / quotient shifting in (DIV)
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Next accumulator/shift values for one iteration of the selected operation
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    step_acc = acc_q;
    step_q   = q_q;
    sum      = '0;
    trial    = '0;
    fits     = 1'b0;
    if (div_sel) begin
      // Shift the next dividend bit into the partial remainder and try
      // subtracting the divisor; the difference always fits in WIDTH bits.
      trial    = {acc_q, q_q[WIDTH-1]};
      fits     = (trial >= {1'b0, opnd_q});
      step_acc = fits ? (trial[WIDTH-1:0] - opnd_q) : trial[WIDTH-1:0];
      step_q   = {q_q[WIDTH-2:0], fits};
    end else begin
      // Add the multiplicand when the current multiplier bit is set, then
      // shift {carry, acc, q} right by one.
      sum      = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : '0);
      step_acc = sum[WIDTH:1];
      step_q   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Working registers and result fields
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      opnd_q      <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (load) begin
        opnd_q <= div_sel ? op_b : op_a;
        q_q    <= div_sel ? op_a : op_b;
        acc_q  <= '0;
      end else if (iterate) begin
        acc_q <= step_acc;
        q_q   <= step_q;
      end

      if (finish) begin
        result      <= step_q;
        remainder   <= div_sel ? step_acc : '0;
        div_by_zero <= div_sel & (opnd_q == '0);
      end else if (early) begin
        // Zero-operand MUL gives 0; DIV by zero gives all ones / dividend.
        result      <= div_sel ? '1 : '0;
        remainder   <= div_sel ? op_a : '0;
        div_by_zero <= div_sel;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle EX-stage sequencer for MUL and DIV. Owns the FSM, iteration
// counter, pipeline stall and flush handling; arithmetic lives in
// ex_muldiv_datapath.
// Optional build macro MULDIV_EARLY_OUT_EN: MUL with a zero operand or DIV
// by zero skips the iterations and goes straight from IDLE to DONE.
module ex_muldiv_sequencer
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  ex_muldiv_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic is_mul;
  logic is_div;
  logic start;
  logic early;
  logic load;
  logic iterate;
  logic finish;
  logic div_sel;

  assign is_mul = (bus.alu_ctrl == ALU_MUL);
  assign is_div = (bus.alu_ctrl == ALU_DIV);
  assign start  = bus.valid_in & ~bus.flush & (is_mul | is_div) & (state_q == IDLE);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = start & ((is_mul & ((bus.op_a == '0) | (bus.op_b == '0))) |
                          (is_div & (bus.op_b == '0)));
`else
  assign early = 1'b0;
`endif

  // While idle the incoming opcode picks the operation; afterwards the state does.
  assign div_sel = (state_q == IDLE) ? is_div : (state_q == RUN_DIV);

  // Next-state, counter and datapath step control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (early) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = is_div ? RUN_DIV : RUN_MUL;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end
      RUN_MUL, RUN_DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          iterate = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and iteration counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy         = (state_q == RUN_MUL) | (state_q == RUN_DIV);
  assign bus.result_valid = (state_q == DONE);
  assign bus.stall        = start | bus.busy;

  ex_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .div_sel     (div_sel),
    .iterate     (iterate),
    .finish      (finish),
    .early       (early),
    .op_a        (bus.op_a),
    .op_b        (bus.op_b),
    .result      (bus.result),
    .remainder   (bus.remainder),
    .div_by_zero (bus.div_by_zero)
  );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer (WIDTH=32).
// Inputs are driven just after the falling edge; outputs are checked 1ns later.
module tb_ex_muldiv_sequencer;
  import ex_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ex_muldiv_sequencer_if #(.WIDTH(W)) bus();

  ex_muldiv_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit takes_early(input logic [4:0] ctrl, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return ((ctrl == ALU_MUL) && (a == '0 || b == '0)) || ((ctrl == ALU_DIV) && (b == '0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic v, input logic f, input logic [4:0] ctrl,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.valid_in = v;
    bus.flush    = f;
    bus.alu_ctrl = ctrl;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, ALU_NOP, '0, '0);
  endtask

  // Holds the instruction in EX from the accept cycle through DONE, checking
  // stall/busy/result_valid every cycle and the result fields in DONE.
  task automatic run_op(input string tag, input logic [4:0] ctrl,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic [W-1:0] exp_rem,
                        input logic exp_dbz);
    int done_cyc;
    done_cyc = takes_early(ctrl, a, b) ? 1 : W + 1;
    for (int c = 0; c <= done_cyc; c++) begin
      drive(1'b1, 1'b0, ctrl, a, b);
      check({tag, " stall"}, bus.stall, (c < done_cyc));
      check({tag, " busy"}, bus.busy, (c >= 1 && c < done_cyc));
      check({tag, " result_valid"}, bus.result_valid, (c == done_cyc));
    end
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " remainder"}, bus.remainder, exp_rem);
    check({tag, " div_by_zero"}, bus.div_by_zero, exp_dbz);
  endtask

  initial begin
    bit seen_rv;

    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    bus.alu_ctrl = ALU_NOP;
    bus.op_a     = '0;
    bus.op_b     = '0;

    // Reset state
    idle(2);
    check("reset busy", bus.busy, 0);
    check("reset result_valid", bus.result_valid, 0);
    check("reset result", bus.result, 0);
    check("reset remainder", bus.remainder, 0);
    check("reset div_by_zero", bus.div_by_zero, 0);
    check("reset stall", bus.stall, 0);
    rst = 1'b0;

    // Main function
    idle(1);
    run_op("mul 7*6", ALU_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    idle(1);
    run_op("div 100/7", ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    idle(1);
    run_op("mul max*2", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0, 1'b0);
    idle(1);
    run_op("div 5/0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    idle(1);
    run_op("mul 0*5", ALU_MUL, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    idle(1);

    // Single-cycle ops bypass the sequencer
    drive(1'b1, 1'b0, ALU_ADD, 32'd3, 32'd4);
    check("add stall", bus.stall, 0);
    drive(1'b0, 1'b0, ALU_NOP, '0, '0);
    check("add busy", bus.busy, 0);
    drive(1'b1, 1'b0, ALU_NOP, '0, '0);
    check("nop stall", bus.stall, 0);

    // Flush in IDLE suppresses start
    drive(1'b1, 1'b1, ALU_MUL, 32'd3, 32'd3);
    check("idle flush stall", bus.stall, 0);
    drive(1'b0, 1'b0, ALU_NOP, '0, '0);
    check("idle flush busy", bus.busy, 0);
    check("idle flush result_valid", bus.result_valid, 0);

    // Back-to-back MUL then DIV: DIV accepted in cycle 34 (its own cycle 0)
    run_op("b2b mul", ALU_MUL, 32'd1000, 32'd1000, 32'd1_000_000, 32'd0, 1'b0);
    run_op("b2b div", ALU_DIV, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);
    idle(1);

    // Flush during RUN_MUL in cycle 10
    for (int c = 0; c <= 10; c++) begin
      drive(1'b1, (c == 10), ALU_MUL, 32'd3, 32'd3);
      if (c == 0)  check("flush start stall", bus.stall, 1);
      if (c == 10) check("flush cycle busy", bus.busy, 1);
    end
    drive(1'b0, 1'b0, ALU_NOP, '0, '0);
    check("after flush stall", bus.stall, 0);
    check("after flush busy", bus.busy, 0);
    seen_rv = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 1'b0, ALU_NOP, '0, '0);
      seen_rv |= bus.result_valid;
    end
    check("flush no result_valid", seen_rv, 0);
    check("flush result held", bus.result, 32'h0FFF_FFFF);
    check("flush remainder held", bus.remainder, 32'd15);

    // Reset during RUN_DIV in cycle 15
    for (int c = 0; c <= 15; c++) begin
      drive(1'b1, 1'b0, ALU_DIV, 32'd100, 32'd7);
      rst = (c == 15);
      if (c == 14) check("pre-reset busy", bus.busy, 1);
    end
    drive(1'b0, 1'b0, ALU_NOP, '0, '0);
    rst = 1'b0;
    check("mid reset busy", bus.busy, 0);
    check("mid reset stall", bus.stall, 0);
    check("mid reset result_valid", bus.result_valid, 0);
    check("mid reset result", bus.result, 0);
    check("mid reset remainder", bus.remainder, 0);
    check("mid reset div_by_zero", bus.div_by_zero, 0);

    // Sequencer usable again after reset
    idle(1);
    run_op("post-reset div 100/7", ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
